// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic-light controller and its side-road sensor.
// Lamp encodings, debounce state type and a counter-width helper.
package traffic_pkg;

  localparam logic [2:0] LAMP_RED = 3'b100;
  localparam logic [2:0] LAMP_YEL = 3'b010;
  localparam logic [2:0] LAMP_GRN = 3'b001;
  localparam logic [2:0] LAMP_RST = 3'b111;

  typedef enum logic [1:0] {IDLE, RISE_CHK, PRESENT, FALL_CHK} db_state_t;

  // Width able to hold 0..n-1; never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/det_debounce.sv
// Loop-detector front end: optional two-flop synchronizer (VRS_DET_SYNC_EN) and
// a four-state debounce FSM that reports one arrival per accepted rising level.
module det_debounce
  import traffic_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic det_raw,
  output logic arrive,
  output logic det_lvl
);

  localparam int DB_W = cnt_w(DEBOUNCE_CYC);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYC - 1);

  logic det_s;

`ifdef VRS_DET_SYNC_EN
  logic sync_p0, sync_p1;

  // Stage boundary: det_raw -> sync_p0 -> sync_p1 (det_s)
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      sync_p0 <= det_raw;
      sync_p1 <= sync_p0;
    end
  end

  assign det_s = sync_p1;
`else
  assign det_s = det_raw;
`endif

  db_state_t       state, state_nxt;
  logic [DB_W-1:0] db_cnt, db_cnt_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      db_cnt <= '0;
    end else begin
      state  <= state_nxt;
      db_cnt <= db_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    db_cnt_nxt = db_cnt;
    arrive     = 1'b0;
    case (state)
      IDLE: begin
        if (det_s) begin
          state_nxt  = RISE_CHK;
          db_cnt_nxt = DB_W'(1);
        end
      end
      RISE_CHK: begin
        if (!det_s) begin
          state_nxt = IDLE;
        end else if (db_cnt == DB_LAST) begin
          state_nxt = PRESENT;
          arrive    = 1'b1;
        end else begin
          db_cnt_nxt = db_cnt + DB_W'(1);
        end
      end
      PRESENT: begin
        if (!det_s) begin
          state_nxt  = FALL_CHK;
          db_cnt_nxt = DB_W'(1);
        end
      end
      FALL_CHK: begin
        if (det_s) begin
          state_nxt = PRESENT;
        end else if (db_cnt == DB_LAST) begin
          state_nxt = IDLE;
        end else begin
          db_cnt_nxt = db_cnt + DB_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign det_lvl = (state == PRESENT) || (state == FALL_CHK);

endmodule

// File: rtl/vehicle_request_sensor.sv
// Side-road vehicle sensor: debounced arrivals, green-time departures, queue
// count and request s. Define VRS_DET_SYNC_EN to include the detector synchronizer.
module vehicle_request_sensor
  import traffic_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 1_000_000,
  parameter int DEPART_CYC   = 100_000_000,
  parameter int QUEUE_W      = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               det_raw,
  input  logic [2:0]         ryg1,
  output logic               s,
  output logic [QUEUE_W-1:0] queue_cnt,
  output logic               arrive_pulse,
  output logic               overflow
);

  localparam int DEP_W = cnt_w(DEPART_CYC);
  localparam logic [DEP_W-1:0]   DEP_LAST = DEP_W'(DEPART_CYC - 1);
  localparam logic [QUEUE_W-1:0] Q_MAX    = {QUEUE_W{1'b1}};

  logic arrive, det_lvl;

  det_debounce #(
    .DEBOUNCE_CYC(DEBOUNCE_CYC)
  ) u_det_debounce (
    .clk    (clk),
    .rst    (rst),
    .det_raw(det_raw),
    .arrive (arrive),
    .det_lvl(det_lvl)
  );

  // An accepted arrival always leaves the debouncer in the vehicle-present level.
  assert property (@(posedge clk) disable iff (rst) arrive |=> det_lvl);

  logic [DEP_W-1:0]   dep_cnt;
  logic [QUEUE_W-1:0] queue_nxt;
  logic               green_busy, depart, ovf_set;

  assign green_busy = (ryg1 == LAMP_GRN) && (queue_cnt != '0);
  assign depart     = green_busy && (dep_cnt == DEP_LAST);

  always_comb begin
    queue_nxt = queue_cnt;
    ovf_set   = 1'b0;
    if (arrive && !depart) begin
      if (queue_cnt == Q_MAX) ovf_set = 1'b1;
      else                    queue_nxt = queue_cnt + QUEUE_W'(1);
    end else if (depart && !arrive) begin
      queue_nxt = queue_cnt - QUEUE_W'(1);
    end
  end

  // Stage boundary: arrival/departure decisions -> registered queue and request
  always_ff @(posedge clk) begin
    if (rst) begin
      dep_cnt      <= '0;
      queue_cnt    <= '0;
      s            <= 1'b0;
      arrive_pulse <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      dep_cnt      <= (green_busy && !depart) ? dep_cnt + DEP_W'(1) : '0;
      queue_cnt    <= queue_nxt;
      s            <= (queue_nxt != '0);
      arrive_pulse <= arrive;
      overflow     <= overflow | ovf_set;
    end
  end

endmodule

// File: tb/tb_vehicle_request_sensor.sv
// Directed and randomized bench for vehicle_request_sensor against a run-length
// reference model; follows VRS_DET_SYNC_EN for the expected arrival latency.
module tb_vehicle_request_sensor;

  localparam int DEB   = 4;
  localparam int DEP   = 8;
  localparam int QW    = 4;
  localparam int QMAX  = (1 << QW) - 1;
`ifdef VRS_DET_SYNC_EN
  localparam bit SYNC  = 1'b1;
`else
  localparam bit SYNC  = 1'b0;
`endif
  localparam int LAT   = SYNC ? DEB + 1 : DEB - 1;
  localparam logic [2:0] RED = 3'b100, YEL = 3'b010, GRN = 3'b001, LRST = 3'b111;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          det_raw = 1'b0;
  logic [2:0]    ryg1 = LRST;
  logic          s;
  logic [QW-1:0] queue_cnt;
  logic          arrive_pulse;
  logic          overflow;

  int checks = 0;
  int errors = 0;

  vehicle_request_sensor #(
    .DEBOUNCE_CYC(DEB),
    .DEPART_CYC  (DEP),
    .QUEUE_W     (QW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .det_raw     (det_raw),
    .ryg1        (ryg1),
    .s           (s),
    .queue_cnt   (queue_cnt),
    .arrive_pulse(arrive_pulse),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  // Reference model: detector level flips after DEB consecutive differing
  // samples; a vehicle leaves after every DEP consecutive busy green edges.
  bit m_sy0, m_sy1, m_lvl, m_ov, m_ap, m_s;
  int m_run, m_g, m_q;

  task automatic model_edge();
    bit ds, arr, dep;
    if (rst) begin
      m_sy0 = 0; m_sy1 = 0; m_lvl = 0; m_run = 0; m_g = 0;
      m_q = 0; m_ov = 0; m_ap = 0; m_s = 0;
    end else begin
      ds = SYNC ? m_sy1 : det_raw;
      m_sy1 = m_sy0;
      m_sy0 = det_raw;
      arr = 0;
      if (ds != m_lvl) begin
        m_run++;
        if (m_run == DEB) begin
          m_lvl = ds;
          m_run = 0;
          arr = ds;
        end
      end else begin
        m_run = 0;
      end
      dep = 0;
      if (ryg1 == GRN && m_q != 0) begin
        m_g++;
        if (m_g == DEP) begin
          dep = 1;
          m_g = 0;
        end
      end else begin
        m_g = 0;
      end
      if (arr && !dep) begin
        if (m_q == QMAX) m_ov = 1;
        else             m_q++;
      end else if (dep && !arr) begin
        m_q--;
      end
      m_ap = arr;
      m_s  = (m_q != 0);
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("model_s", 32'(s), 32'(m_s));
    chk("model_queue_cnt", 32'(queue_cnt), 32'(m_q));
    chk("model_arrive_pulse", 32'(arrive_pulse), 32'(m_ap));
    chk("model_overflow", 32'(overflow), 32'(m_ov));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic arrive_one();
    det_raw = 1'b1;
    repeat (8) step();
    det_raw = 1'b0;
    repeat (8) step();
  endtask

  initial begin
    int first_arr, n_arr, hold, idx;

    // Reset state
    rst = 1'b1; det_raw = 1'b1; ryg1 = LRST;
    step(); step();
    chk("reset_s", 32'(s), 0);
    chk("reset_queue", 32'(queue_cnt), 0);
    chk("reset_arrive", 32'(arrive_pulse), 0);
    chk("reset_overflow", 32'(overflow), 0);
    det_raw = 1'b0;
    step();

    // Clean arrival
    rst = 1'b0; ryg1 = RED; det_raw = 1'b1;
    first_arr = -1; n_arr = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (arrive_pulse) begin
        n_arr++;
        if (first_arr < 0) first_arr = i;
      end
    end
    chk("clean_latency", 32'(first_arr), 32'(LAT));
    chk("clean_count", 32'(n_arr), 1);
    chk("clean_queue", 32'(queue_cnt), 1);
    chk("clean_s", 32'(s), 1);
    det_raw = 1'b0;
    repeat (10) step();

    // Bounce rejection
    do_reset();
    repeat (5) begin
      det_raw = 1'b1; step(); step();
      det_raw = 1'b0; step();
    end
    repeat (6) step();
    chk("bounce_queue", 32'(queue_cnt), 0);
    chk("bounce_s", 32'(s), 0);

    // Discharge of three vehicles
    ryg1 = RED;
    repeat (3) arrive_one();
    chk("discharge_start", 32'(queue_cnt), 3);
    ryg1 = GRN;
    for (int k = 1; k <= 24; k++) begin
      step();
      if (k == 7)  chk("discharge_k7", 32'(queue_cnt), 3);
      if (k == 8)  chk("discharge_k8", 32'(queue_cnt), 2);
      if (k == 16) chk("discharge_k16", 32'(queue_cnt), 1);
      if (k == 23) chk("discharge_s_k23", 32'(s), 1);
      if (k == 24) begin
        chk("discharge_k24", 32'(queue_cnt), 0);
        chk("discharge_s_k24", 32'(s), 0);
      end
    end

    // Yellow interruption discards the partial count
    ryg1 = RED;
    arrive_one();
    ryg1 = GRN;
    repeat (5) step();
    ryg1 = YEL;
    step();
    chk("yellow_no_dep", 32'(queue_cnt), 1);
    ryg1 = GRN;
    repeat (7) step();
    chk("restart_early", 32'(queue_cnt), 1);
    step();
    chk("restart_dep", 32'(queue_cnt), 0);

    // Arrival coinciding with departure
    ryg1 = RED;
    repeat (2) arrive_one();
    chk("simul_start", 32'(queue_cnt), 2);
    ryg1 = GRN;
    for (int i = 1; i <= 8; i++) begin
      if (i == 8 - LAT) det_raw = 1'b1;
      step();
    end
    chk("simul_arrive", 32'(arrive_pulse), 1);
    chk("simul_queue", 32'(queue_cnt), 2);
    chk("simul_overflow", 32'(overflow), 0);
    ryg1 = RED; det_raw = 1'b0;
    repeat (10) step();

    // Saturation and sticky overflow
    do_reset();
    ryg1 = RED;
    for (int a = 1; a <= 16; a++) begin
      arrive_one();
      if (a == 15) begin
        chk("sat_q15", 32'(queue_cnt), 15);
        chk("sat_ov15", 32'(overflow), 0);
      end
    end
    chk("sat_q16", 32'(queue_cnt), 15);
    chk("sat_ov16", 32'(overflow), 1);
    ryg1 = GRN;
    repeat (8) step();
    chk("sat_after_dep", 32'(queue_cnt), 14);
    chk("sat_ov_sticky", 32'(overflow), 1);
    ryg1 = RED;
    do_reset();
    chk("sat_ov_cleared", 32'(overflow), 0);

    // Reset while checking a rising edge
    det_raw = 1'b1;
    repeat (3) step();
    rst = 1'b1;
    step();
    chk("midrst_s", 32'(s), 0);
    chk("midrst_queue", 32'(queue_cnt), 0);
    chk("midrst_arrive", 32'(arrive_pulse), 0);
    chk("midrst_overflow", 32'(overflow), 0);
    rst = 1'b0;
    idx = -1;
    for (int i = 0; i < 40; i++) begin
      step();
      if (arrive_pulse && idx < 0) idx = i;
    end
    chk("midrst_latency", 32'(idx), 32'(LAT));
    det_raw = 1'b0;
    repeat (10) step();

    // Randomized traffic
    hold = 0;
    for (int c = 0; c < 3000; c++) begin
      if (hold == 0) begin
        det_raw = $urandom_range(0, 1);
        hold = $urandom_range(1, 9);
      end
      hold--;
      if ($urandom_range(0, 19) == 0) begin
        case ($urandom_range(0, 7))
          0:       ryg1 = LRST;
          1, 2:    ryg1 = YEL;
          3, 4:    ryg1 = RED;
          default: ryg1 = GRN;
        endcase
      end
      rst = ($urandom_range(0, 399) == 0);
      step();
    end
    rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vehicle_request_sensor.md
# vehicle_request_sensor

Side-road vehicle sensor front-end for the traffic-light controller: it debounces a raw loop-detector input, keeps a count of vehicles waiting on the side road, and drives the controller's side-road request `s`. It watches the side-road lamp vector `ryg1` coming back from the controller to retire queued vehicles while the side road is green. It runs on the system clock, not the 1 Hz tick, so `s` is stable long before the controller samples it.

## Interface
- `DEBOUNCE_CYC`, default 1_000_000: consecutive equal samples needed to accept a detector level change. Must be ≥ 2.
- `DEPART_CYC`, default 100_000_000: side-road-green cycles per departing vehicle. Must be ≥ 1.
- `QUEUE_W`, default 4: queue counter width; maximum count is 2^QUEUE_W − 1.
- `clk` input 1: system clock.
- `rst` input 1: **synchronous, active-high reset; one clock (`clk`).**
- `det_raw` input 1: raw loop detector, asynchronous, bouncy; 1 = vehicle over loop.
- `ryg1` input 3: side-road lamp from the controller. One-hot {red, yellow, green}: 100 red, 010 yellow, 001 green. 111 is the controller's reset pattern.
- `s` output 1: registered side-road request to the controller; 1 whenever the queue is non-zero.
- `queue_cnt` output QUEUE_W: vehicles waiting.
- `arrive_pulse` output 1: one-cycle pulse per accepted vehicle arrival.
- `overflow` output 1: sticky flag; set when an arrival is dropped at full queue.

## Operation
- Synchronizer: two flops on `det_raw` produce `det_s`; both flops reset to 0.
- Debounce FSM, evaluated on `det_s`, with counter `db_cnt`:
  - IDLE: if `det_s` = 1, go to RISE_CHK and set `db_cnt` = 1.
  - RISE_CHK: if `det_s` = 0, go to IDLE. If `db_cnt` = DEBOUNCE_CYC−1, go to PRESENT and fire an arrival. Otherwise increment `db_cnt`.
  - PRESENT: if `det_s` = 0, go to FALL_CHK and set `db_cnt` = 1.
  - FALL_CHK: if `det_s` = 1, go to PRESENT. If `db_cnt` = DEBOUNCE_CYC−1, go to IDLE. Otherwise increment `db_cnt`.
  - Arrival means the debounced rising edge only. A vehicle parked on the loop counts once.
- Departure timer `dep_cnt`:
  - Increments on each edge where `ryg1` = 001 and `queue_cnt` ≠ 0.
  - When it reaches DEPART_CYC−1, that edge is a departure and `dep_cnt` returns to 0.
  - `dep_cnt` is cleared to 0 on any edge where `ryg1` ≠ 001 (including 111) or `queue_cnt` = 0.
- Queue update, one edge:
  - Arrival only: +1. At the maximum count it stays at maximum and `overflow` is set.
  - Departure only: −1. A departure never occurs at 0.
  - Arrival and departure together: unchanged, and `overflow` is not set.
- `s` is registered as (next `queue_cnt` ≠ 0), so it changes on the same edge as `queue_cnt`.
- `overflow` clears only on `rst`.

## Timing
- On an edge with `rst` = 1, the following are cleared, regardless of any other input:
  - FSM state to IDLE.
  - Both synchronizer flops, `db_cnt` and `dep_cnt` to 0.
  - Outputs `s`, `queue_cnt`, `arrive_pulse` and `overflow` to 0.
- Detector held high through reset is not counted until it has been re-debounced from IDLE; the count restarts from the first edge with `rst` = 0.
- Arrival latency, with `det_raw` rising before edge E0:
  - `det_s` is high after E1.
  - The arrival edge is E(DEBOUNCE_CYC+1). `arrive_pulse`, `queue_cnt` += 1 and `s` = 1 all become visible after it.
  - `arrive_pulse` is high for exactly one cycle.
- A glitch shorter than DEBOUNCE_CYC samples of `det_s` causes no arrival. A drop-out shorter than DEBOUNCE_CYC samples while PRESENT causes no second arrival.
- Departures occur every DEPART_CYC edges of continuous green while the queue is non-zero. `s` falls on the edge where the queue reaches 0.
- A green→yellow transition mid-count discards the partial `dep_cnt`.

## Configuration
- `VRS_DET_SYNC_EN` defined: two-flop synchronizer present; arrival latency is as stated above.
- `VRS_DET_SYNC_EN` undefined: `det_s` = `det_raw` directly, intended for synchronous simulation benches. The arrival edge becomes E(DEBOUNCE_CYC−1), counting from the first edge that samples `det_raw` = 1.
- All other behaviour is identical in both builds.

## Structure
- Shared package `traffic_pkg`:
  - Lamp constants LAMP_RED = 3'b100, LAMP_YEL = 3'b010, LAMP_GRN = 3'b001, LAMP_RST = 3'b111.
  - Debounce state enum {IDLE, RISE_CHK, PRESENT, FALL_CHK}.
- Counter widths are $clog2 of the parameters.
- One sub-module, `det_debounce`: synchronizer, FSM and `db_cnt`. Its outputs are `arrive` and the debounced level.
- The top level holds `dep_cnt`, the queue, `s` and `overflow`.

## Test plan
All directed tests use DEBOUNCE_CYC = 4, DEPART_CYC = 8, QUEUE_W = 4, with sync compiled in.
- **Clean arrival:** reset, `ryg1` = 100, then `det_raw` = 1 held for 20 cycles from before E0 → `arrive_pulse` high for exactly one cycle after E5; `queue_cnt` = 1, `s` = 1; no further arrivals.
- **Bounce rejection:** `det_raw` pulses high for 2 cycles, repeated 5 times with 1-cycle gaps → `queue_cnt` stays 0 and `s` stays 0.
- **Discharge:** `queue_cnt` = 3, `ryg1` = 001 → departures every 8 edges; `queue_cnt` steps 2, 1, 0; `s` falls with the third departure. Switching `ryg1` to 010 after 5 green edges → no departure, and `dep_cnt` restarts.
- **Simultaneous events:** arrival edge coincides with departure edge at `queue_cnt` = 2 → `queue_cnt` stays 2 and `overflow` stays 0.
- **Saturation:** 16 clean arrivals with `ryg1` = 100 → `queue_cnt` = 15, `overflow` = 1 after the 16th; `overflow` persists until reset.
- **Reset mid-operation:** `rst` pulsed while in RISE_CHK with `det_raw` held high → all outputs 0; the next arrival occurs DEBOUNCE_CYC+1 edges after `rst` falls, per the stated latency.
